multi_func_generator: RTL and testbench
=======================================

# multi_func_generator

Parametrised multi-channel phase-accumulator function generator. It replaces the single-channel, switch-driven amplitude/frequency selector with the following:
- per-channel programmable frequency, waveform and amplitude;
- a valid/ready configuration port;
- glitch-free frequency retuning.

It sits between the clock source and the DAC/sample sink and emits one OUT_W-bit sample per channel per enabled cycle.

## Interface
- CHANNELS, 2, number of independent channels (≥1)
- OUT_W, 8, sample width (≥4)
- ACC_W, 16, phase accumulator width (≥OUT_W)
- CH_W, derived: max(1, $clog2(CHANNELS))

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset; clears all state
- en  in  1  global run enable
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config port can accept a write
- cfg_ch  in  CH_W  target channel
- cfg_addr  in  2  register select:
  - 0 = increment
  - 1 = {mode[1:0], amp[1:0]} in cfg_data[3:0]
  - 2 = duty (cfg_data[OUT_W-1:0])
  - 3 = phase load
- cfg_data  in  ACC_W  write data
- wave_out  out  CHANNELS*OUT_W  samples; channel c occupies [c*OUT_W +: OUT_W]
- wave_valid  out  1  wave_out holds a fresh sample
- sync_out  out  CHANNELS  per-channel wrap marker, aligned with wave_out

## Operation
- Per channel state:
  - acc[ACC_W]
  - inc[ACC_W]
  - pend_inc[ACC_W] plus a pend flag
  - mode[1:0]: 0 square, 1 sawtooth, 2 triangle, 3 off
  - amp[1:0]
  - duty[OUT_W]
- Write acceptance: a write is accepted when cfg_valid && cfg_ready. If cfg_ch ≥ CHANNELS, the write is accepted and ignored.
- Write effects by address:
  - addr 0: loads pend_inc and sets pend.
  - addr 1 and addr 2: take effect on the next edge.
  - addr 3: acc <= cfg_data on the next edge, overriding that cycle's accumulate.
- cfg_ready = no channel has pend set. All writes are blocked while any retune is outstanding.
- Accumulation: with en=1, each edge does acc <= acc + inc (mod 2^ACC_W). Wrap = carry-out of that add.
- Pending increment is applied as inc <= pend_inc and pend cleared on the first of:
  - the channel's wrap edge;
  - any edge with en=0;
  - any edge with inc==0 (prevents deadlock).
  The add on that edge uses the old inc.
- Phase p = acc[ACC_W-1 -: OUT_W]. Raw shapes:
  - saw: p
  - triangle: {p[OUT_W-2:0],1'b0} when p MSB=0, else its bitwise inverse
  - square: all-ones if p < duty, else 0
  - off: 0
- Amplitude: sample = raw >> amp (logical, divides by 1/2/4/8).
- en=0: acc, wave_out and sync_out hold; wave_valid=0. Config writes are still accepted.

## Timing
- Reset values:
  - acc, inc, pend_inc = 0; pend = 0
  - mode = 3 (off); amp = 0; duty = 2^(OUT_W-1)
  - wave_out = 0; wave_valid = 0; sync_out = 0
  - cfg_ready = 1
- Reset assertion clears state immediately, including mid-retune. The first sample after release appears one edge after en=1.
- Output latency: wave_out is registered from the pre-increment acc. A sample for acc value A appears on the edge that advances acc from A.
- wave_valid = registered en (1 cycle latency).
- Sync: sync_out[c]=1 for exactly the enabled cycle whose wave_out shows the first sample after wrap (acc wrapped on the previous edge). Phase load does not generate sync.
- Mode/amp/duty writes are visible in wave_out two edges after acceptance.
- cfg_ready drops the cycle after an increment write is accepted. It rises the cycle after the apply edge.

## Configuration
- Macro: MULTI_FUNC_GEN_DUTY_EN.
- Defined: the duty register is writable and square uses p < duty.
  - duty=0 gives constant 0.
  - duty reset is 2^(OUT_W-1).
- Undefined: duty is a constant 2^(OUT_W-1), giving a fixed 50% square. addr 2 writes are accepted and ignored.

## Test plan
Default parameters are used unless stated.
1. rst low mid-run -> wave_out=0, wave_valid=0, sync_out=0 and cfg_ready=1 immediately. Outputs stay 0 after release until a mode is written.
2. ch0 inc=0x0100, saw, amp=0, en=1 -> wave_out[7:0] = 0,1,2,…,255,0. sync_out[0] pulses every 256 cycles, on the sample 0.
3. ch1 inc=0x0200, triangle -> 0,4,8,…,252,255,251,…,3,0. ch0 runs concurrently and is unaffected.
4. ch0 saw inc=0x0100; at acc=0x3000 write inc=0x0400 -> the following holds:
   - cfg_ready is low until the wrap 0xFF00→0x0000.
   - Samples continue +1 until the wrap, then go 0,4,8….
   - A second write held on cfg_valid during this period is stalled, then accepted.
5. Square, amp=2, inc=0x0100 -> 0x3F for 128 samples, then 0x00 for 128.
6. With MULTI_FUNC_GEN_DUTY_EN, duty=0x40 -> high for 64 of 256 samples. Without the macro, the same write leaves the 128/128 split.

Source files
------------

// File: rtl/multi_func_generator.sv
// Multi-channel phase-accumulator function generator with square/saw/triangle shapes,
// per-channel amplitude, valid/ready config port and wrap-aligned retuning. Optional: MULTI_FUNC_GEN_DUTY_EN.
module multi_func_generator #(
  parameter  int CHANNELS = 2,
  parameter  int OUT_W    = 8,
  parameter  int ACC_W    = 16,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [CH_W-1:0]           cfg_ch,
  input  logic [1:0]                cfg_addr,
  input  logic [ACC_W-1:0]          cfg_data,
  output logic [CHANNELS*OUT_W-1:0] wave_out,
  output logic                      wave_valid,
  output logic [CHANNELS-1:0]       sync_out
);

  localparam logic [CH_W:0]    CH_LIM   = (CH_W+1)'(CHANNELS);
  localparam logic [OUT_W-1:0] DUTY_MID = {1'b1, {(OUT_W-1){1'b0}}};

  // Shape the phase into a raw sample, then attenuate by a logical right shift.
  function automatic logic [OUT_W-1:0] shape_fn(
    input logic [OUT_W-1:0] p,
    input logic [1:0]       mode,
    input logic [1:0]       amp,
    input logic [OUT_W-1:0] duty
  );
    logic [OUT_W-1:0] raw;
    case (mode)
      2'd0:    raw = (p < duty) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
      2'd1:    raw = p;
      2'd2:    raw = p[OUT_W-1] ? ~{p[OUT_W-2:0], 1'b0} : {p[OUT_W-2:0], 1'b0};
      default: raw = {OUT_W{1'b0}};
    endcase
    return raw >> amp;
  endfunction

  logic                  cfg_ready_s;
  logic                  ch_ok_s;
  logic                  wr_s;
  logic [OUT_W-1:0]      smp_s [CHANNELS];
  logic [CHANNELS-1:0]   pend_s;
  logic [CHANNELS-1:0]   wrapf_s;

  // Any outstanding retune freezes the whole port so no write can race an apply edge.
  assign cfg_ready_s = ~|pend_s;
  assign cfg_ready   = cfg_ready_s;
  assign ch_ok_s     = {1'b0, cfg_ch} < CH_LIM;
  assign wr_s        = cfg_valid & cfg_ready_s & ch_ok_s;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] inc_r;
    logic [ACC_W-1:0] pend_inc_r;
    logic             pend_r;
    logic             wrapf_r;
    logic [1:0]       mode_r;
    logic [1:0]       amp_r;
    logic [OUT_W-1:0] duty_s;
    logic             sel_s;
    logic             load_s;
    logic [ACC_W:0]   sum_s;
    logic             wrap_s;
    logic             apply_s;

    assign sel_s   = wr_s && (cfg_ch == CH_W'(c));
    assign load_s  = sel_s && (cfg_addr == 2'd3);
    assign sum_s   = {1'b0, acc_r} + {1'b0, inc_r};
    assign wrap_s  = sum_s[ACC_W];
    // Retune lands on a wrap, while paused, or when a zero increment could never wrap.
    assign apply_s = pend_r && (!en || wrap_s || (inc_r == {ACC_W{1'b0}}));

    // Phase accumulation, pending-increment handling and wrap tracking.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        acc_r      <= {ACC_W{1'b0}};
        inc_r      <= {ACC_W{1'b0}};
        pend_inc_r <= {ACC_W{1'b0}};
        pend_r     <= 1'b0;
        wrapf_r    <= 1'b0;
      end else begin
        if (load_s) begin
          acc_r   <= cfg_data;
          wrapf_r <= 1'b0;
        end else if (en) begin
          acc_r   <= sum_s[ACC_W-1:0];
          wrapf_r <= wrap_s;
        end
        if (apply_s) begin
          inc_r  <= pend_inc_r;
          pend_r <= 1'b0;
        end else if (sel_s && (cfg_addr == 2'd0)) begin
          pend_inc_r <= cfg_data;
          pend_r     <= 1'b1;
        end
      end
    end

    // Waveform selection and attenuation registers.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        mode_r <= 2'd3;
        amp_r  <= 2'd0;
      end else if (sel_s && (cfg_addr == 2'd1)) begin
        mode_r <= cfg_data[3:2];
        amp_r  <= cfg_data[1:0];
      end
    end

`ifdef MULTI_FUNC_GEN_DUTY_EN
    logic [OUT_W-1:0] duty_r;

    // Programmable square-wave threshold.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        duty_r <= DUTY_MID;
      end else if (sel_s && (cfg_addr == 2'd2)) begin
        duty_r <= cfg_data[OUT_W-1:0];
      end
    end
    assign duty_s = duty_r;
`else
    assign duty_s = DUTY_MID;
`endif

    assign smp_s[c]   = shape_fn(acc_r[ACC_W-1 -: OUT_W], mode_r, amp_r, duty_s);
    assign pend_s[c]  = pend_r;
    assign wrapf_s[c] = wrapf_r;
  end

  // Output stage: samples come from the pre-increment phase and hold while paused.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wave_out   <= {(CHANNELS*OUT_W){1'b0}};
      wave_valid <= 1'b0;
      sync_out   <= {CHANNELS{1'b0}};
    end else begin
      wave_valid <= en;
      if (en) begin
        for (int i = 0; i < CHANNELS; i++) begin
          wave_out[i*OUT_W +: OUT_W] <= smp_s[i];
        end
        sync_out <= wrapf_s;
      end
    end
  end

endmodule

// File: tb/tb_multi_func_generator.sv
// Directed self-checking bench for multi_func_generator (default parameters, 2 channels, 8-bit samples).
module tb_multi_func_generator;

  logic        clk;
  logic        rst;
  logic        en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [0:0]  cfg_ch;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic [15:0] wave_out;
  logic        wave_valid;
  logic [1:0]  sync_out;

  int checks;
  int errors;

  multi_func_generator dut (
    .clk(clk), .rst(rst), .en(en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .wave_out(wave_out), .wave_valid(wave_valid), .sync_out(sync_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b0; cfg_valid = 1'b0;
    cfg_ch = 1'b0; cfg_addr = 2'd0; cfg_data = 16'h0000;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic cfg_write(input logic [0:0] ch, input logic [1:0] addr, input logic [15:0] data);
    int n;
    n = 0;
    cfg_valid = 1'b1; cfg_ch = ch; cfg_addr = addr; cfg_data = data;
    while (!cfg_ready && n < 1000) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL cfg_write_timeout: cfg_ready=%0b required 1", cfg_ready);
    end
    tick();
    cfg_valid = 1'b0;
  endtask

  // Paused writes of mode/amp and increment, then one paused edge to apply the increment.
  task automatic setup_ch(input logic [0:0] ch, input logic [15:0] modeamp, input logic [15:0] inc);
    cfg_write(ch, 2'd1, modeamp);
    cfg_write(ch, 2'd0, inc);
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (wave_out !== 16'h0000 || wave_valid !== 1'b0 || sync_out !== 2'b00 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: wave=%h valid=%b sync=%b ready=%b required 0000 0 00 1",
               wave_out, wave_valid, sync_out, cfg_ready);
    end
    setup_ch(1'b0, 16'h0004, 16'h1000);
    en = 1'b1;
    repeat (3) tick();
    cfg_write(1'b0, 2'd0, 16'h2000);
    checks++;
    if (cfg_ready !== 1'b0 || wave_out[7:0] !== 8'h30) begin
      errors++;
      $display("FAIL pre_reset_run: ready=%b wave=%h required 0 30", cfg_ready, wave_out[7:0]);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (wave_out !== 16'h0000 || wave_valid !== 1'b0 || sync_out !== 2'b00 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: wave=%h valid=%b sync=%b ready=%b required 0000 0 00 1",
               wave_out, wave_valid, sync_out, cfg_ready);
    end
    repeat (2) tick();
    rst = 1'b1;
    en = 1'b1;
    repeat (3) tick();
    checks++;
    if (wave_out !== 16'h0000 || wave_valid !== 1'b1 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_off: wave=%h valid=%b ready=%b required 0000 1 1", wave_out, wave_valid, cfg_ready);
    end
  endtask

  task automatic test_saw();
    logic [7:0] exp8;
    do_reset();
    setup_ch(1'b0, 16'h0004, 16'h0100);
    en = 1'b1;
    for (int k = 0; k <= 256; k++) begin
      tick();
      exp8 = 8'(k % 256);
      checks++;
      if (wave_out[7:0] !== exp8 || sync_out !== {1'b0, (k == 256)} || wave_valid !== 1'b1) begin
        errors++;
        $display("FAIL saw k=%0d: wave=%h sync=%b valid=%b required %h %b 1",
                 k, wave_out[7:0], sync_out, wave_valid, exp8, {1'b0, (k == 256)});
      end
    end
    checks++;
    if (wave_out[15:8] !== 8'h00) begin
      errors++;
      $display("FAIL saw_ch1_off: wave=%h required 00", wave_out[15:8]);
    end
  endtask

  task automatic test_triangle();
    int p;
    logic [7:0] exp1;
    logic [7:0] exp0;
    do_reset();
    setup_ch(1'b0, 16'h0004, 16'h0100);
    setup_ch(1'b1, 16'h0008, 16'h0200);
    en = 1'b1;
    for (int k = 0; k <= 128; k++) begin
      tick();
      p = (2 * k) % 256;
      exp1 = (p < 128) ? 8'(2 * p) : 8'(255 - 2 * (p - 128));
      exp0 = 8'(k % 256);
      checks++;
      if (wave_out[15:8] !== exp1 || wave_out[7:0] !== exp0 || sync_out !== {(k == 128), 1'b0}) begin
        errors++;
        $display("FAIL triangle k=%0d: ch1=%h ch0=%h sync=%b required %h %h %b",
                 k, wave_out[15:8], wave_out[7:0], sync_out, exp1, exp0, {(k == 128), 1'b0});
      end
    end
  endtask

  task automatic test_retune();
    do_reset();
    setup_ch(1'b0, 16'h0004, 16'h0100);
    en = 1'b1;
    repeat (48) tick();
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_addr = 2'd0; cfg_data = 16'h0400;
    tick();
    checks++;
    if (cfg_ready !== 1'b0 || wave_out[7:0] !== 8'd48) begin
      errors++;
      $display("FAIL retune_accept: ready=%b wave=%h required 0 30", cfg_ready, wave_out[7:0]);
    end
    cfg_ch = 1'b1; cfg_addr = 2'd1; cfg_data = 16'h0000;
    for (int k = 49; k <= 255; k++) begin
      tick();
      checks++;
      if (wave_out[7:0] !== 8'(k) || wave_out[15:8] !== 8'h00 || cfg_ready !== (k == 255)) begin
        errors++;
        $display("FAIL retune_wait k=%0d: ch0=%h ch1=%h ready=%b required %h 00 %b",
                 k, wave_out[7:0], wave_out[15:8], cfg_ready, 8'(k), (k == 255));
      end
    end
    tick();
    cfg_valid = 1'b0;
    checks++;
    if (wave_out[7:0] !== 8'h00 || sync_out[0] !== 1'b1) begin
      errors++;
      $display("FAIL retune_wrap: wave=%h sync0=%b required 00 1", wave_out[7:0], sync_out[0]);
    end
    for (int j = 1; j <= 3; j++) begin
      tick();
      checks++;
      if (wave_out[7:0] !== 8'(4 * j) || wave_out[15:8] !== 8'hFF) begin
        errors++;
        $display("FAIL retune_new j=%0d: ch0=%h ch1=%h required %h FF", j, wave_out[7:0], wave_out[15:8], 8'(4 * j));
      end
    end
  endtask

  task automatic test_square();
    int hi;
    logic [7:0] exp8;
    hi = 0;
    do_reset();
    setup_ch(1'b0, 16'h0002, 16'h0100);
    en = 1'b1;
    for (int k = 0; k < 256; k++) begin
      tick();
      exp8 = (k < 128) ? 8'h3F : 8'h00;
      if (wave_out[7:0] == 8'h3F) hi++;
      checks++;
      if (wave_out[7:0] !== exp8) begin
        errors++;
        $display("FAIL square k=%0d: wave=%h required %h", k, wave_out[7:0], exp8);
      end
    end
    checks++;
    if (hi != 128) begin
      errors++;
      $display("FAIL square_count: high=%0d required 128", hi);
    end
  endtask

  task automatic test_duty();
    int hi;
    int lim;
    logic [7:0] exp8;
`ifdef MULTI_FUNC_GEN_DUTY_EN
    lim = 64;
`else
    lim = 128;
`endif
    hi = 0;
    do_reset();
    cfg_write(1'b0, 2'd2, 16'h0040);
    setup_ch(1'b0, 16'h0000, 16'h0100);
    en = 1'b1;
    for (int k = 0; k < 256; k++) begin
      tick();
      exp8 = (k < lim) ? 8'hFF : 8'h00;
      if (wave_out[7:0] == 8'hFF) hi++;
      checks++;
      if (wave_out[7:0] !== exp8) begin
        errors++;
        $display("FAIL duty k=%0d: wave=%h required %h", k, wave_out[7:0], exp8);
      end
    end
    checks++;
    if (hi != lim) begin
      errors++;
      $display("FAIL duty_count: high=%0d required %0d", hi, lim);
    end
  endtask

  task automatic test_hold_phase();
    do_reset();
    setup_ch(1'b0, 16'h0004, 16'h0100);
    en = 1'b1;
    repeat (3) tick();
    en = 1'b0;
    repeat (2) tick();
    checks++;
    if (wave_out[7:0] !== 8'h02 || wave_valid !== 1'b0 || sync_out !== 2'b00) begin
      errors++;
      $display("FAIL hold: wave=%h valid=%b sync=%b required 02 0 00", wave_out[7:0], wave_valid, sync_out);
    end
    cfg_write(1'b0, 2'd3, 16'h8000);
    en = 1'b1;
    tick();
    checks++;
    if (wave_out[7:0] !== 8'h80 || sync_out !== 2'b00 || wave_valid !== 1'b1) begin
      errors++;
      $display("FAIL phase_load: wave=%h sync=%b valid=%b required 80 00 1", wave_out[7:0], sync_out, wave_valid);
    end
    tick();
    checks++;
    if (wave_out[7:0] !== 8'h81) begin
      errors++;
      $display("FAIL phase_next: wave=%h required 81", wave_out[7:0]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0; en = 1'b0; cfg_valid = 1'b0;
    cfg_ch = 1'b0; cfg_addr = 2'd0; cfg_data = 16'h0000;
    test_reset();
    test_saw();
    test_triangle();
    test_retune();
    test_square();
    test_duty();
    test_hold_phase();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
